gsim_fwd: RTL and testbench

Forward operator for the Gauss-Seidel solver datapath. Accepts a 16-element solution vector x (signed Q16.16) as a stream and computes b = A·x. A is the fixed 16×16 banded matrix: diagonal 20, off-diagonal ±1 = −13, ±2 = 6, ±3 = −1. It streams out the 16 resulting b words (signed 16-bit integers). It sits on the opposite side of the solver interface: it produces the b stream the solver consumes, from the x stream the solver emits, and is used for residual checking and stimulus generation.

---
 rtl/gsim_pkg.sv | 35 +++
 rtl/gsim_fwd_row.sv | 97 +++++++++
 rtl/gsim_fwd.sv | 108 ++++++++++
 tb/tb_gsim_fwd.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gsim_pkg.sv
// Shared types and constants for the Gauss-Seidel forward operator (b = A*x).
package gsim_pkg;

  localparam int unsigned N     = 16;
  localparam int unsigned X_W   = 32;
  localparam int unsigned B_W   = 16;
  localparam int unsigned ACC_W = 40;
  localparam int unsigned FRAC  = 16;
  localparam int unsigned S_W   = X_W + 1;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned NBR   = 7;

  // Band coefficients: diagonal, then distance 1, 2, 3 (magnitudes)
  localparam int unsigned C0 = 20;
  localparam int unsigned C1 = 13;
  localparam int unsigned C2 = 6;
  localparam int unsigned C3 = 1;

  localparam logic signed [ACC_W-1:0] RND   = ACC_W'(1 << (FRAC - 1));
  localparam logic signed [ACC_W-1:0] B_MAX = ACC_W'((2 ** (B_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] B_MIN = ACC_W'(-(2 ** (B_W - 1)));

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  // Neighbour window for one row: slot d holds X[i+d-3]; mask marks in-range slots.
  typedef struct packed {
    logic [NBR-1:0]          mask;
    logic [NBR-1:0][X_W-1:0] x;
  } nbr_t;

endpackage

// File: rtl/gsim_fwd_row.sv
// Three-stage row pipeline: neighbour sums, shift-add accumulate, round/narrow.
// GSIM_FWD_SAT_EN selects saturating narrowing; otherwise the result wraps.
module gsim_fwd_row
  import gsim_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           issue,
  input  nbr_t           nbr,
  output logic           out_valid,
  output logic [B_W-1:0] b_out
);

  logic                    v1;
  logic                    v2;
  logic signed [X_W-1:0]   x0_c;
  logic signed [X_W-1:0]   x0_q;
  logic signed [S_W-1:0]   s1_c, s2_c, s3_c;
  logic signed [S_W-1:0]   s1_q, s2_q, s3_q;
  logic signed [ACC_W-1:0] e0, e1, e2, e3;
  logic signed [ACC_W-1:0] acc_c;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] r_c;
  logic [B_W-1:0]          b_c;

  function automatic logic signed [S_W-1:0] pair_sum(
    input logic [X_W-1:0] a, input logic ma,
    input logic [X_W-1:0] b, input logic mb
  );
    logic signed [S_W-1:0] ea;
    logic signed [S_W-1:0] eb;
    ea = ma ? S_W'($signed(a)) : '0;
    eb = mb ? S_W'($signed(b)) : '0;
    return ea + eb;
  endfunction

  // S1: symmetric neighbour sums, out-of-range slots contribute zero
  always_comb begin
    x0_c = nbr.mask[3] ? $signed(nbr.x[3]) : '0;
    s1_c = pair_sum(nbr.x[2], nbr.mask[2], nbr.x[4], nbr.mask[4]);
    s2_c = pair_sum(nbr.x[1], nbr.mask[1], nbr.x[5], nbr.mask[5]);
    s3_c = pair_sum(nbr.x[0], nbr.mask[0], nbr.x[6], nbr.mask[6]);
  end

  // S2: 20*x0 - 13*s1 + 6*s2 - s3 using shifts and adds only
  always_comb begin
    e0    = ACC_W'(x0_q);
    e1    = ACC_W'(s1_q);
    e2    = ACC_W'(s2_q);
    e3    = ACC_W'(s3_q);
    acc_c = (e0 <<< 4) + (e0 <<< 2)
          - ((e1 <<< 3) + (e1 <<< 2) + e1)
          + (e2 <<< 2) + (e2 <<< 1)
          - e3;
  end

  // S3: round half toward +inf, then narrow to B_W
  always_comb begin
    r_c = (acc_q + RND) >>> FRAC;
`ifdef GSIM_FWD_SAT_EN
    if (r_c > B_MAX) begin
      b_c = {1'b0, {(B_W - 1){1'b1}}};
    end else if (r_c < B_MIN) begin
      b_c = {1'b1, {(B_W - 1){1'b0}}};
    end else begin
      b_c = B_W'(r_c);
    end
`else
    b_c = B_W'(r_c);
`endif
  end

  always_ff @(posedge clk) begin
    x0_q  <= x0_c;
    s1_q  <= s1_c;
    s2_q  <= s2_c;
    s3_q  <= s3_c;
    acc_q <= acc_c;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      b_out     <= '0;
    end else begin
      v1        <= issue;
      v2        <= v1;
      out_valid <= v2;
      if (v2) begin
        b_out <= b_c;
      end
    end
  end

endmodule

// File: rtl/gsim_fwd.sv
// Forward operator top: loads a 16-word x frame, streams out b = A*x.
// Build option GSIM_FWD_SAT_EN saturates b instead of wrapping.
module gsim_fwd
  import gsim_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           in_en,
  input  logic [X_W-1:0] x_in,
  output logic           in_ready,
  output logic           out_valid,
  output logic [B_W-1:0] b_out
);

  state_t             state, state_nx;
  logic [IDX_W-1:0]   ld_cnt, ld_cnt_nx;
  logic [IDX_W-1:0]   row_cnt, row_cnt_nx;
  logic [IDX_W-1:0]   out_cnt, out_cnt_nx;
  logic [X_W-1:0]     xbuf [N];
  logic               accept_c;
  logic               issue_c;
  nbr_t               nbr_c;

  assign accept_c = in_en && in_ready;
  assign issue_c  = (state == COMPUTE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= LOAD;
      ld_cnt   <= '0;
      row_cnt  <= '0;
      out_cnt  <= '0;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nx;
      ld_cnt   <= ld_cnt_nx;
      row_cnt  <= row_cnt_nx;
      out_cnt  <= out_cnt_nx;
      in_ready <= (state_nx == LOAD);
    end
  end

  // Next state and counters; out_cnt tracks delivered b words of the frame
  always_comb begin
    state_nx   = state;
    ld_cnt_nx  = ld_cnt;
    row_cnt_nx = row_cnt;
    out_cnt_nx = out_cnt;
    if (out_valid) begin
      out_cnt_nx = out_cnt + IDX_W'(1);
    end
    unique case (state)
      LOAD: begin
        if (accept_c) begin
          ld_cnt_nx = ld_cnt + IDX_W'(1);
          if (ld_cnt == IDX_W'(N - 1)) begin
            state_nx  = COMPUTE;
            ld_cnt_nx = '0;
          end
        end
      end
      COMPUTE: begin
        row_cnt_nx = row_cnt + IDX_W'(1);
        if (row_cnt == IDX_W'(N - 1)) begin
          state_nx   = OUTPUT;
          row_cnt_nx = '0;
        end
      end
      OUTPUT: begin
        if (out_valid && (out_cnt == IDX_W'(N - 1))) begin
          state_nx   = LOAD;
          ld_cnt_nx  = '0;
          row_cnt_nx = '0;
          out_cnt_nx = '0;
        end
      end
      default: begin
        state_nx = LOAD;
      end
    endcase
  end

  // X buffer is intentionally not reset; each frame rewrites all 16 words
  always_ff @(posedge clk) begin
    if (reset && accept_c) begin
      xbuf[ld_cnt] <= x_in;
    end
  end

  // Neighbour window around the issuing row; slot d maps to X[row+d-3]
  always_comb begin
    nbr_c = '0;
    for (int d = 0; d < int'(NBR); d++) begin
      nbr_c.mask[d] = ((int'(row_cnt) + d) >= 3) && ((int'(row_cnt) + d) < (int'(N) + 3));
      nbr_c.x[d]    = xbuf[IDX_W'(int'(row_cnt) + d - 3)];
    end
  end

  gsim_fwd_row u_row (
    .clk       (clk),
    .reset     (reset),
    .issue     (issue_c),
    .nbr       (nbr_c),
    .out_valid (out_valid),
    .b_out     (b_out)
  );

endmodule

// File: tb/tb_gsim_fwd.sv
// Self-checking bench for gsim_fwd: vector table plus scoreboard of expected b words.
module tb_gsim_fwd;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_en;
  logic [31:0] x_in;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] b_out;

  typedef struct packed {
    logic [15:0][31:0] x;
    logic [15:0][15:0] b;
  } vec_t;

  typedef struct {
    logic [15:0] b;
    int          fr;
    int          idx;
  } sb_t;

  vec_t tbl [5];
  sb_t  sb_q [$];
  sb_t  mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  gsim_fwd dut (
    .clk       (clk),
    .reset     (reset),
    .in_en     (in_en),
    .x_in      (x_in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .b_out     (b_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, got, exp);
    end
  endtask

  // Independent reference: dense band matrix with ordinary multiplies.
  function automatic logic [15:0][15:0] ref_b(input logic [15:0][31:0] x);
    logic [15:0][15:0] b;
    longint acc, r, c;
    int d;
    for (int i = 0; i < 16; i++) begin
      acc = 0;
      for (int j = 0; j < 16; j++) begin
        d = (i > j) ? i - j : j - i;
        c = (d == 0) ? 20 : (d == 1) ? -13 : (d == 2) ? 6 : (d == 3) ? -1 : 0;
        acc += c * longint'($signed(x[j]));
      end
      r = (acc + 32768) >>> 16;
`ifdef GSIM_FWD_SAT_EN
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
`endif
      b[i] = r[15:0];
    end
    return b;
  endfunction

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got b_out=%h with out_valid, want no output", b_out);
      end else begin
        mon_e = sb_q.pop_front();
        chk($sformatf("frame%0d_b%0d", mon_e.fr, mon_e.idx), 32'(b_out), 32'(mon_e.b));
      end
    end
  end

  task automatic send_frame(input int fr, input logic [15:0][31:0] x,
                            input logic [15:0][15:0] b, input bit gaps);
    int guard;
    for (int i = 0; i < 16; i++) sb_q.push_back('{b: b[i], fr: fr, idx: i});
    for (int k = 0; k < 16; k++) begin
      guard = 0;
      // Junk pulses while not ready must be ignored by the DUT
      while (in_ready !== 1'b1) begin
        in_en = 1'($urandom_range(0, 1));
        x_in  = $urandom;
        @(posedge clk); #1;
        guard++;
        if (guard > 200) begin
          n_cmp++;
          n_err++;
          $display("FAIL ready_timeout: frame %0d word %0d in_ready=%b, want 1", fr, k, in_ready);
          in_en = 1'b0;
          return;
        end
      end
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        in_en = 1'b0;
        x_in  = $urandom;
        @(posedge clk); #1;
      end
      in_en = 1'b1;
      x_in  = x[k];
      @(posedge clk); #1;
    end
    in_en = 1'b0;
  endtask

  task automatic drain(output int first_ov, output int n_ov, output int cyc);
    first_ov = -1;
    n_ov     = 0;
    cyc      = 0;
    while (in_ready !== 1'b1 && cyc < 200) begin
      if (out_valid === 1'b1) begin
        if (first_ov < 0) first_ov = cyc;
        n_ov++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: in_ready=%b after %0d cycles, want 1", in_ready, cyc);
    end
  endtask

  initial begin
    logic [15:0][31:0] xr;
    logic [15:0][15:0] br;
    int first_ov, n_ov, cyc, cnt, guard;

    tbl[0].x = '0;
    tbl[0].b = '0;

    tbl[1].x = '0;
    tbl[1].x[0] = 32'h0001_0000;
    tbl[1].b = '0;
    tbl[1].b[0] = 16'd20;
    tbl[1].b[1] = 16'hFFF3;
    tbl[1].b[2] = 16'd6;
    tbl[1].b[3] = 16'hFFFF;

    for (int i = 0; i < 16; i++) begin
      tbl[2].x[i] = 32'h0001_0000;
      tbl[2].b[i] = 16'd4;
    end
    tbl[2].b[0]  = 16'd12;
    tbl[2].b[1]  = 16'hFFFF;
    tbl[2].b[2]  = 16'd5;
    tbl[2].b[13] = 16'd5;
    tbl[2].b[14] = 16'hFFFF;
    tbl[2].b[15] = 16'd12;

    // 0.5 at x[5]: distance-3 rows give -0.5 which rounds up to 0
    tbl[3].x = '0;
    tbl[3].x[5] = 32'h0000_8000;
    tbl[3].b = '0;
    tbl[3].b[3] = 16'd3;
    tbl[3].b[4] = 16'hFFFA;
    tbl[3].b[5] = 16'd10;
    tbl[3].b[6] = 16'hFFFA;
    tbl[3].b[7] = 16'd3;

    tbl[4].x = '0;
    tbl[4].x[0] = 32'h7FFF_0000;
    tbl[4].b = '0;
`ifdef GSIM_FWD_SAT_EN
    tbl[4].b[0] = 16'h7FFF;
    tbl[4].b[1] = 16'h8000;
    tbl[4].b[2] = 16'h7FFF;
    tbl[4].b[3] = 16'h8001;
`else
    tbl[4].b[0] = 16'hFFEC;
    tbl[4].b[1] = 16'h800D;
    tbl[4].b[2] = 16'hFFFA;
    tbl[4].b[3] = 16'h8001;
`endif

    reset = 1'b0;
    in_en = 1'b0;
    x_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_b_out", 32'(b_out), 32'd0);

    // Zero frame with latency/handshake timing measured
    send_frame(0, tbl[0].x, tbl[0].b, 1'b0);
    drain(first_ov, n_ov, cyc);
    chk("first_out_latency", 32'(first_ov), 32'd3);
    chk("out_valid_count", 32'(n_ov), 32'd16);
    chk("in_ready_low_cycles", 32'(cyc), 32'd19);

    // Table frames back to back, with gaps and junk pulses
    for (int t = 1; t < 5; t++) begin
      send_frame(t, tbl[t].x, tbl[t].b, 1'(t % 2));
    end

    for (int f = 5; f < 8; f++) begin
      for (int k = 0; k < 16; k++) xr[k] = $urandom;
      br = ref_b(xr);
      send_frame(f, xr, br, 1'b1);
    end
    drain(first_ov, n_ov, cyc);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_b_out", 32'(b_out), 32'(br[15]));
    chk("idle_out_valid", 32'(out_valid), 32'd0);

    // Reset during the 8th output cycle discards the rest of the frame
    for (int k = 0; k < 16; k++) xr[k] = $urandom;
    send_frame(10, xr, ref_b(xr), 1'b0);
    cnt   = 0;
    guard = 0;
    while (guard < 100) begin
      if (out_valid === 1'b1) cnt++;
      if (cnt == 8) break;
      @(posedge clk); #1;
      guard++;
    end
    chk("reset_point_reached", 32'(cnt), 32'd8);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_b_out", 32'(b_out), 32'd0);
    sb_q.delete();

    send_frame(11, tbl[2].x, tbl[2].b, 1'b1);
    drain(first_ov, n_ov, cyc);
    chk("post_reset_ov_count", 32'(n_ov), 32'd16);
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
